// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider between two EX-stage slots.
// Converts owner flushes into a timed divider annul so the divider always ends up free.
module div_arbiter #(
    parameter int ABORT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        signed0_i,
    input  logic        signed1_i,
    input  logic [31:0] op1_0_i,
    input  logic [31:0] op1_1_i,
    input  logic [31:0] op2_0_i,
    input  logic [31:0] op2_1_i,
    input  logic        flush0_i,
    input  logic        flush1_i,
    output logic        stall0_o,
    output logic        stall1_o,
    output logic        done0_o,
    output logic        done1_o,
    output logic [63:0] result_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ABORT
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_own;
    logic        w_nextOwn;
    logic        r_last;
    logic        w_nextLast;
    logic        r_start;
    logic        w_nextStart;
    logic        r_annul;
    logic        w_nextAnnul;
    logic        r_signed;
    logic        w_nextSigned;
    logic [31:0] r_op1;
    logic [31:0] w_nextOp1;
    logic [31:0] r_op2;
    logic [31:0] w_nextOp2;
    logic [63:0] r_result;
    logic [63:0] w_nextResult;
    logic        r_done0;
    logic        w_nextDone0;
    logic        r_done1;
    logic        w_nextDone1;
    logic [1:0]  r_abortCnt;
    logic [1:0]  w_nextAbortCnt;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_grantAny;
    logic        w_grantOne;
    logic        w_flushOwn;
    logic        w_abortLast;

    assign w_elig0     = req0_i & ~flush0_i;
    assign w_elig1     = req1_i & ~flush1_i;
    assign w_grantAny  = w_elig0 | w_elig1;
    // On a tie the requester that was not served last wins.
    assign w_grantOne  = w_elig1 & (~w_elig0 | ~r_last);
    assign w_flushOwn  = r_own ? flush1_i : flush0_i;
    assign w_abortLast = (r_abortCnt == 2'(ABORT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_own      <= 1'b0;
            r_last     <= 1'b1;
            r_start    <= 1'b0;
            r_annul    <= 1'b0;
            r_signed   <= 1'b0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_result   <= 64'd0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_abortCnt <= 2'd0;
        end else begin
            r_state    <= w_nextState;
            r_own      <= w_nextOwn;
            r_last     <= w_nextLast;
            r_start    <= w_nextStart;
            r_annul    <= w_nextAnnul;
            r_signed   <= w_nextSigned;
            r_op1      <= w_nextOp1;
            r_op2      <= w_nextOp2;
            r_result   <= w_nextResult;
            r_done0    <= w_nextDone0;
            r_done1    <= w_nextDone1;
            r_abortCnt <= w_nextAbortCnt;
        end
    end

    // Operands are only rewritten on a grant; the divider re-reads their signs at completion.
    always_comb begin
        w_nextState    = r_state;
        w_nextOwn      = r_own;
        w_nextLast     = r_last;
        w_nextStart    = r_start;
        w_nextAnnul    = r_annul;
        w_nextSigned   = r_signed;
        w_nextOp1      = r_op1;
        w_nextOp2      = r_op2;
        w_nextResult   = r_result;
        w_nextDone0    = 1'b0;
        w_nextDone1    = 1'b0;
        w_nextAbortCnt = r_abortCnt;

        unique case (r_state)
            IDLE: begin
                if (w_grantAny) begin
                    w_nextOwn    = w_grantOne;
                    w_nextLast   = w_grantOne;
                    w_nextSigned = w_grantOne ? signed1_i : signed0_i;
                    w_nextOp1    = w_grantOne ? op1_1_i : op1_0_i;
                    w_nextOp2    = w_grantOne ? op2_1_i : op2_0_i;
                    w_nextStart  = 1'b1;
                    w_nextAnnul  = 1'b0;
                    w_nextState  = BUSY;
                end
            end
            BUSY: begin
                if (w_flushOwn) begin
                    w_nextStart    = 1'b0;
                    w_nextAnnul    = 1'b1;
                    w_nextAbortCnt = 2'd0;
                    w_nextState    = ABORT;
                end else if (div_ready_i) begin
                    w_nextResult = div_result_i;
                    w_nextStart  = 1'b0;
                    w_nextDone0  = ~r_own;
                    w_nextDone1  = r_own;
                    w_nextState  = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            ABORT: begin
                // Annul is held long enough to cover every divider state it may be in.
                if (w_abortLast) begin
                    w_nextAnnul = 1'b0;
                    w_nextState = IDLE;
                end else begin
                    w_nextAbortCnt = r_abortCnt + 2'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign done0_o      = r_done0 & ~flush0_i;
    assign done1_o      = r_done1 & ~flush1_i;
    assign stall0_o     = req0_i & ~done0_o & ~flush0_i;
    assign stall1_o     = req1_i & ~done1_o & ~flush1_i;
    assign result_o     = r_result;
    assign div_start_o  = r_start;
    assign div_annul_o  = r_annul;
    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: emulated divider, transaction-level reference model checked
// every cycle, and literal completion expectations (requester, result, cycle).
module tb_div_arbiter;

    localparam int ABORT = 2;
    localparam int LAT_NZ = 37;
    localparam int LAT_Z = 3;

    logic        clk;
    logic        rst;
    logic        req0_i, req1_i, signed0_i, signed1_i, flush0_i, flush1_i;
    logic [31:0] op1_0_i, op1_1_i, op2_0_i, op2_1_i;
    logic        stall0_o, stall1_o, done0_o, done1_o;
    logic [63:0] result_o;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    div_arbiter #(.ABORT_CYCLES(ABORT)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0_i), .req1_i(req1_i),
        .signed0_i(signed0_i), .signed1_i(signed1_i),
        .op1_0_i(op1_0_i), .op1_1_i(op1_1_i),
        .op2_0_i(op2_0_i), .op2_1_i(op2_1_i),
        .flush0_i(flush0_i), .flush1_i(flush1_i),
        .stall0_o(stall0_o), .stall1_o(stall1_o),
        .done0_o(done0_o), .done1_o(done1_o),
        .result_o(result_o),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    // Reference quotient/remainder, truncating toward zero; divide by zero gives 0.
    function automatic logic [63:0] divRef(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sq, sr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    // Divider emulation: ready after 35 start cycles (1 for divisor 0); start low or annul frees it.
    logic [5:0] divCnt;
    always @(posedge clk or posedge rst) begin
        if (rst)
            divCnt <= 6'd0;
        else if (div_start_o && !div_annul_o)
            divCnt <= (divCnt == 6'd63) ? divCnt : divCnt + 6'd1;
        else
            divCnt <= 6'd0;
    end
    assign div_ready_i  = div_start_o & ~div_annul_o & (divCnt >= ((div_op2_o == 32'd0) ? 6'd1 : 6'd35));
    assign div_result_i = divRef(div_signed_o, div_op1_o, div_op2_o);

    typedef struct {
        int          who;
        logic [63:0] res;
        int          doneAt;
    } exp_t;
    exp_t expQ[$];
    int   expIdx;
    int   timeoutCount;
    int   seenTimeouts;
    int   checks;
    int   failures;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model state: one transaction in flight, its owner, grant/done cycles and the annul window.
    bit          mActive;
    int          mOwner, mLast, mGrantCyc, mDoneCyc, mFreeAt, mAnnulFrom, mAnnulTo;
    logic        mSigned;
    logic [31:0] mOp1, mOp2;
    logic [63:0] mResult, mPendRes;

    initial begin
        logic expDone0, expDone1, expStart, expAnnul, e0, e1, fOwn;
        int   w;
        exp_t e;
        expIdx = 0;
        seenTimeouts = 0;
        checks = 0;
        failures = 0;
        forever begin
            @(negedge clk);
            if (timeoutCount > seenTimeouts) begin
                seenTimeouts++;
                checks++;
                failures++;
                $display("[TB] FAIL wait_bound: got timeout, want completion at cycle %0d", cyc);
            end
            if (rst) begin
                checkOutput("rst_start", div_start_o, 0);
                checkOutput("rst_annul", div_annul_o, 0);
                checkOutput("rst_signed", div_signed_o, 0);
                checkOutput("rst_op1", div_op1_o, 0);
                checkOutput("rst_op2", div_op2_o, 0);
                checkOutput("rst_result", result_o, 0);
                checkOutput("rst_done0", done0_o, 0);
                checkOutput("rst_done1", done1_o, 0);
                checkOutput("rst_stall0", stall0_o, req0_i & ~flush0_i);
                checkOutput("rst_stall1", stall1_o, req1_i & ~flush1_i);
                mActive = 0; mOwner = 0; mLast = 1; mGrantCyc = 0; mDoneCyc = 0;
                mFreeAt = 0; mAnnulFrom = -1; mAnnulTo = -2;
                mSigned = 0; mOp1 = 0; mOp2 = 0; mResult = 0; mPendRes = 0;
            end else begin
                if (mActive && cyc == mDoneCyc) mResult = mPendRes;
                expStart = mActive && cyc > mGrantCyc && cyc < mDoneCyc;
                expAnnul = cyc >= mAnnulFrom && cyc <= mAnnulTo;
                expDone0 = mActive && cyc == mDoneCyc && mOwner == 0 && !flush0_i;
                expDone1 = mActive && cyc == mDoneCyc && mOwner == 1 && !flush1_i;
                checkOutput("start", div_start_o, expStart);
                checkOutput("annul", div_annul_o, expAnnul);
                checkOutput("signed", div_signed_o, mSigned);
                checkOutput("op1", div_op1_o, mOp1);
                checkOutput("op2", div_op2_o, mOp2);
                checkOutput("result", result_o, mResult);
                checkOutput("done0", done0_o, expDone0);
                checkOutput("done1", done1_o, expDone1);
                checkOutput("stall0", stall0_o, req0_i & ~expDone0 & ~flush0_i);
                checkOutput("stall1", stall1_o, req1_i & ~expDone1 & ~flush1_i);

                if (done0_o || done1_o) begin
                    if (expIdx < expQ.size()) begin
                        e = expQ[expIdx];
                        expIdx++;
                        checkOutput("lit_who", done1_o ? 1 : 0, e.who);
                        checkOutput("lit_result", result_o, e.res);
                        checkOutput("lit_cycle", cyc, e.doneAt);
                    end else begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL lit_extra: got done pulse, want none at cycle %0d", cyc);
                    end
                end

                fOwn = (mOwner == 1) ? flush1_i : flush0_i;
                if (mActive && cyc > mGrantCyc && cyc < mDoneCyc && fOwn) begin
                    mActive = 0;
                    mAnnulFrom = cyc + 1;
                    mAnnulTo = cyc + ABORT;
                    mFreeAt = cyc + 1 + ABORT;
                end else if (mActive && cyc == mDoneCyc) begin
                    mActive = 0;
                    mFreeAt = cyc + 1;
                end else if (!mActive && cyc >= mFreeAt) begin
                    e0 = req0_i & ~flush0_i;
                    e1 = req1_i & ~flush1_i;
                    if (e0 || e1) begin
                        w = (e0 && e1) ? (1 - mLast) : (e1 ? 1 : 0);
                        mOwner = w;
                        mLast = w;
                        mSigned = (w == 1) ? signed1_i : signed0_i;
                        mOp1 = (w == 1) ? op1_1_i : op1_0_i;
                        mOp2 = (w == 1) ? op2_1_i : op2_0_i;
                        mPendRes = divRef(mSigned, mOp1, mOp2);
                        mGrantCyc = cyc;
                        mDoneCyc = cyc + ((mOp2 == 32'd0) ? LAT_Z : LAT_NZ);
                        mActive = 1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int who, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (who == 0) begin
            req0_i = 1'b1; signed0_i = sgn; op1_0_i = a; op2_0_i = b;
        end else begin
            req1_i = 1'b1; signed1_i = sgn; op1_1_i = a; op2_1_i = b;
        end
    endtask

    // Requester side: hold the request until its done pulse, then drop it.
    task automatic serve(input int who);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((who == 0 && done0_o) || (who == 1 && done1_o)) break;
        end
        if (n == 200) timeoutCount++;
        @(posedge clk);
        #1;
        if (who == 0) req0_i = 1'b0;
        else req1_i = 1'b0;
    endtask

    task automatic runOp(input int who, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res);
        @(posedge clk);
        #1;
        expQ.push_back('{who, res, cyc + ((b == 32'd0) ? LAT_Z : LAT_NZ)});
        applyStimulus(who, sgn, a, b);
        serve(who);
    endtask

    int r;
    initial begin
        rst = 1'b1;
        timeoutCount = 0;
        req0_i = 0; req1_i = 0; signed0_i = 0; signed1_i = 0; flush0_i = 0; flush1_i = 0;
        op1_0_i = 0; op1_1_i = 0; op2_0_i = 0; op2_1_i = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Simultaneous requests after reset: requester 0 first.
        @(posedge clk);
        #1;
        r = cyc;
        expQ.push_back('{0, 64'h00000001_00000004, r + LAT_NZ});
        expQ.push_back('{1, 64'h00000002_00000002, r + 2 * LAT_NZ + 1});
        applyStimulus(0, 1'b0, 32'd9, 32'd2);
        applyStimulus(1, 1'b0, 32'd8, 32'd3);
        fork
            serve(0);
            serve(1);
        join

        runOp(0, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // Requester 0 was served last, so requester 1 wins the tie now.
        @(posedge clk);
        #1;
        r = cyc;
        expQ.push_back('{1, 64'h00000002_00000002, r + LAT_NZ});
        expQ.push_back('{0, 64'h00000001_00000004, r + 2 * LAT_NZ + 1});
        applyStimulus(0, 1'b0, 32'd9, 32'd2);
        applyStimulus(1, 1'b0, 32'd8, 32'd3);
        fork
            serve(0);
            serve(1);
        join

        runOp(1, 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

        // Owner flush 10 cycles into BUSY, then a request raised together with its own flush.
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        req0_i = 1'b0;
        flush0_i = 1'b1;
        @(posedge clk);
        #1;
        flush0_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 32'd40, 32'd4);
        flush1_i = 1'b1;
        @(posedge clk);
        #1;
        req1_i = 1'b0;
        flush1_i = 1'b0;
        runOp(0, 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

        runOp(0, 1'b0, 32'd123, 32'd0, 64'd0);
        runOp(1, 1'b0, 32'd7, 32'd7, 64'h00000000_00000001);

        // Asynchronous reset in the middle of a signed divide.
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b1, 32'hFFFFFE0C, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        req1_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        runOp(1, 1'b0, 32'd20, 32'd6, 64'h00000002_00000003);

        for (int n = 0; n < 50 && expIdx != expQ.size(); n++) @(posedge clk);
        if (expIdx != expQ.size()) timeoutCount++;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Controller that shares the single multi-cycle `div` unit between two requesters (EX-stage slot 0 and slot 1). It arbitrates round-robin and latches the winner's operands. It then drives the divider's `start_i`/`annul_i`/`signed_div_i`/operand inputs, waits for `ready_o`, and returns the 64-bit result with a one-cycle done pulse. Per-requester flushes are converted into divider annuls, and the divider is left in its free state in every case.

## Interface

Parameters:
- `ABORT_CYCLES`, default 2: cycles spent in ABORT with divider start low and annul high.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req0_i` / `req1_i`  in  1  divide request; held high until the matching `doneN_o` or `flushN_i`.
- `signed0_i` / `signed1_i`  in  1  1 = signed divide.
- `op1_0_i` / `op1_1_i`  in  32  dividend.
- `op2_0_i` / `op2_1_i`  in  32  divisor.
- `flush0_i` / `flush1_i`  in  1  cancel requester N's operation (pipeline flush).
- `stall0_o` / `stall1_o`  out  1  requester N must hold; combinational `reqN_i & ~doneN_o & ~flushN_i`.
- `done0_o` / `done1_o`  out  1  one-cycle pulse; `result_o` valid.
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}.
- `div_start_o`  out  1  to divider `start_i`; registered.
- `div_annul_o`  out  1  to divider `annul_i`; registered.
- `div_signed_o`  out  1  to divider `signed_div_i`; registered.
- `div_op1_o` / `div_op2_o`  out  32  to divider operands; registered.
- `div_result_i`  in  64  from divider `result_o`.
- `div_ready_i`  in  1  from divider `ready_o`.

## Operation

- States: IDLE, BUSY, DONE, ABORT. Owner register `own` (0/1). Round-robin pointer `last` holds the last granted requester.
- Eligibility: requester N is eligible when `reqN_i & ~flushN_i`.
- **IDLE**
  - Both requesters eligible: grant `~last`. One eligible: grant it.
  - On grant: latch `signedN_i`, `op1_N_i`, `op2_N_i` into the `div_*` registers; `own <= N`; `last <= N`; `div_start_o <= 1`; go to BUSY.
  - Operands stay constant until the next grant. The divider samples operand signs again at completion, so the registered operands must not change while BUSY.
- **BUSY**
  - `flush[own]` high: `div_start_o <= 0`, `div_annul_o <= 1`, go to ABORT.
  - Otherwise, when `div_ready_i` is high: `result_o <= div_result_i`, `div_start_o <= 0`, `done[own] <= 1`, go to DONE.
- **DONE** (one cycle)
  - `done[own]` high; `doneN_o` is gated by `~flushN_i`.
  - Divider sees start low, returns to its free state.
  - Next state IDLE; done register clears.
- **ABORT**
  - Lasts `ABORT_CYCLES` cycles, counted by a 2-bit counter.
  - Covers divider in DivOn (annul frees it), DivByZero (goes to DivEnd), and DivEnd (start low frees it).
  - Then `div_annul_o <= 0`, go to IDLE.
- Non-owner flush or request drop while BUSY has no effect on the divider.
- Divisor 0 is passed through; the divider returns 0 and the arbiter reports it as a normal completion.
- `result_o` holds its value until the next completion.

## Timing

- Reset (async, any state, including mid-divide): state IDLE, `last` = 1 so requester 0 wins the first tie.
  - `div_start_o`, `div_annul_o`, `div_signed_o`, `div_op1_o`, `div_op2_o`, `result_o`, `done0_o`, `done1_o` all 0.
  - Stalls follow their combinational equation.
- Grant edge: `div_start_o` is high in the next cycle.
- Completion: `doneN_o` is high exactly in the cycle after the first cycle with `div_ready_i` high in BUSY. With the current divider this is 37 cycles after the grant edge for a nonzero divisor.
- Back-to-back: a new grant can occur in the IDLE cycle after DONE, so there are at least 2 cycles between `div_start_o` pulses.
- `req` and `flush` for the same requester in the same IDLE cycle: no grant.
- Flush and `div_ready_i` in the same BUSY cycle: flush wins, go to ABORT, no done.

## Test plan

- Unsigned 100/7, requester 0 only -> `done0_o` pulses once; `result_o` = 0x00000002_0000000E; `stall0_o` high from request until the done cycle.
- Signed -100/7 (op1 = 0xFFFFFF9C), requester 1 -> `result_o` = 0xFFFFFFFE_FFFFFFF2; `div_signed_o` = 1 throughout BUSY.
- Both requesters raise req in the same cycle after reset (req0: 9/2, req1: 8/3) -> requester 0 is served first (0x00000001_00000004), then requester 1 (0x00000002_00000002); then both request again -> requester 0 wins next (round-robin).
- Requester 0 flushed 10 cycles into BUSY -> `div_annul_o` high for 2 cycles, no `done0_o`; a following 50/5 request completes with 0x00000000_0000000A.
- Divide 123/0 -> `done` pulses with `result_o` = 0; a following 7/7 completes with 0x00000000_00000001.
- `rst` asserted mid-BUSY -> all outputs 0 asynchronously; state IDLE; the next request is granted normally.
